sequence_player: RTL and testbench
==================================

Name: sequence_player

Overview:
- Generates, stores and plays back the Simon colour sequence on the shared num/pressed interface.
- It is the transmitting end of that interface; the button interpreter is the player-side producer and the LED, frequency and speaker blocks are the consumers.
- A free-running LFSR supplies a new random entry on each round extension.
- A tick-paced FSM presents each stored entry as a timed press followed by a gap.
- A read port exposes stored entries so the player-input checker can compare against them.

Parameters:
- IDX_W, 5: index width; MAX_LEN = 2**IDX_W entries (32).
- ON_TICKS, 3: tick pulses for which pressed stays high per entry; legal range 1..15.
- OFF_TICKS, 1: tick pulses of silence after each entry; legal range 1..15.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pacing strobe from the clock reducer, in the clk domain.
- clear  in  1  empty the sequence (new game).
- extend  in  1  append one random entry.
- start  in  1  request playback of the whole sequence.
- rd_idx  in  IDX_W  checker read index.
- rd_num  out  2  stored entry at rd_idx.
- length  out  IDX_W+1  number of stored entries.
- full  out  1  length == MAX_LEN.
- num  out  2  colour being played.
- pressed  out  1  high while an entry is sounding.
- busy  out  1  playback in progress.
- done  out  1  one-cycle pulse when playback completes.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, length=0, counters=0, lfsr=LFSR_SEED.
  - num=0, pressed=0, busy=0, done=0.
  - Memory contents are don't-care.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every clk cycle, not gated by tick.
  - Because it is free-running, the value sampled depends on player timing.
- extend, accepted only when state==IDLE, clear==0 and full==0:
  - mem[length] <= lfsr[1:0]; length <= length+1, both on the same edge.
  - extend when full, or when not IDLE, is ignored with no state change.
- clear:
  - Sets length=0 on the next edge.
  - If asserted mid-playback: aborts to IDLE, pressed=0, busy=0, no done pulse.
  - clear has priority over extend and start.
- rd_num = mem[rd_idx], combinational read.
  - rd_idx >= length returns stale data; the checker must not rely on it.
- FSM states: IDLE, ON, OFF, FIN.
  - IDLE:
    - start && length>0: idx=0, cnt=0, go to ON next cycle.
    - start && length==0: go directly to FIN, producing done with no press.
  - ON:
    - num=mem[idx], pressed=1.
    - cnt increments on each tick.
    - On the tick where cnt==ON_TICKS-1: cnt=0, go to OFF.
  - OFF:
    - pressed=0; num holds its last value.
    - On the tick where cnt==OFF_TICKS-1: if idx==length-1 go to FIN, else idx+1 and go to ON.
  - FIN:
    - done=1 for exactly one cycle, busy=1, then IDLE.
- busy is high in ON, OFF and FIN. num=0 in IDLE and FIN.
- start while busy is ignored and not queued.
- Latency: start at cycle t gives pressed=1 at t+1, independent of tick phase.
- A tick coinciding with the start cycle is not counted.
- Outputs num, pressed, busy and done are registered (glitch-free for the speaker).
- length has IDX_W+1 bits; idx and cnt never wrap past their limits.

Decomposition:
- Shared simon_pkg:
  - Colour encoding constants (GREEN=0, RED=1, YELLOW=2, BLUE=3).
  - Player FSM state enum.
  - LFSR tap constant.
  - The checker reuses the colour constants.
- One sub-module, simon_lfsr: 16-bit free-running LFSR with seed parameter and 2-bit output.
- Memory is an inline register array (32x2 bits, no RAM macro).

Test Plan:
- Reset with tick every 4 cycles, then 3 extend pulses → length=3, full=0; rd_num at idx 0..2 matches a reference LFSR model from seed ACE1 at the sampled cycles.
- length=3, start → 3 pressed pulses, each high for 3 ticks and separated by 1 tick low; num follows mem[0..2]; done pulses exactly once, 1 cycle after the last OFF tick; busy covers start+1 through the done cycle.
- length=0, start → no pressed; done=1 at t+1; busy=1 for exactly that cycle.
- 32 extends then a 33rd extend → full=1, length=32; the 33rd is ignored and mem[31] is unchanged.
- clear asserted during the second ON entry → pressed=0 and busy=0 on the next cycle, no done, length=0; a later start gives done with no press.
- start and extend asserted while busy → both ignored, length unchanged, playback uninterrupted; reset asserted mid-ON → outputs drop to 0 immediately (asynchronously).

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon blocks: colour codes, player FSM states
// and the sequence LFSR polynomial.
package simon_pkg;

    localparam logic [1:0] COL_GREEN  = 2'd0;
    localparam logic [1:0] COL_RED    = 2'd1;
    localparam logic [1:0] COL_YELLOW = 2'd2;
    localparam logic [1:0] COL_BLUE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_FIN  = 2'd3
    } play_state_e;

    // Taps 16,14,13,11 expressed as a bit mask over lfsr[15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; the low two bits serve as a colour.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [1:0] rnd_o
);

    logic [15:0] lfsr_q;

    // Advance every clock so the sampled value depends on player timing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign rnd_o = lfsr_q[1:0];

endmodule

// File: rtl/sequence_player.sv
// Stores the Simon colour sequence and plays it back as tick-timed presses
// on the num/pressed interface.
module sequence_player
    import simon_pkg::*;
#(
    parameter int          IDX_W     = 5,
    parameter int          ON_TICKS  = 3,
    parameter int          OFF_TICKS = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             clear,
    input  logic             extend,
    input  logic             start,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_num,
    output logic [IDX_W:0]   length,
    output logic             full,
    output logic [1:0]       num,
    output logic             pressed,
    output logic             busy,
    output logic             done
);

    localparam int MAX_LEN = 1 << IDX_W;

    play_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W:0]   length_q;
    logic [1:0]       mem_q [MAX_LEN];
    logic [1:0]       num_q, num_d;
    logic             pressed_q, pressed_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       rnd_s;
    logic             full_s;
    logic             ext_ok_s;
    logic             last_s;

    simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i  (clk),
        .rst_ni (reset),
        .rnd_o  (rnd_s)
    );

    assign full_s   = (length_q == (IDX_W+1)'(MAX_LEN));
    assign ext_ok_s = extend && !clear && !full_s && (state_q == ST_IDLE);
    assign last_s   = ({1'b0, idx_q} == (length_q - (IDX_W+1)'(1)));

    // Sequence storage; contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (ext_ok_s) begin
            mem_q[length_q[IDX_W-1:0]] <= rnd_s;
        end
    end

    // State, counters, length and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= 4'd0;
            length_q  <= '0;
            num_q     <= 2'd0;
            pressed_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            length_q  <= clear ? '0 : (ext_ok_s ? length_q + (IDX_W+1)'(1) : length_q);
            num_q     <= num_d;
            pressed_q <= pressed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; clear overrides everything, ticks pace ON and OFF.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_d   = '0;
                        cnt_d   = 4'd0;
                        state_d = (length_q != '0) ? ST_ON : ST_FIN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ON: begin
                    if (tick && (cnt_q == 4'(ON_TICKS - 1))) begin
                        cnt_d   = 4'd0;
                        state_d = ST_OFF;
                    end else if (tick) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_OFF: begin
                    if (tick && (cnt_q == 4'(OFF_TICKS - 1))) begin
                        cnt_d = 4'd0;
                        if (last_s) begin
                            state_d = ST_FIN;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = ST_ON;
                        end
                    end else if (tick) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs derived from the upcoming state so they register glitch-free.
    always_comb begin
        num_d     = 2'd0;
        pressed_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_d)
            ST_ON: begin
                num_d     = mem_q[idx_d];
                pressed_d = 1'b1;
                busy_d    = 1'b1;
            end
            ST_OFF: begin
                num_d  = num_q;
                busy_d = 1'b1;
            end
            ST_FIN: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: num_d = 2'd0;
        endcase
    end

    assign rd_num  = mem_q[rd_idx];
    assign length  = length_q;
    assign full    = full_s;
    assign num     = num_q;
    assign pressed = pressed_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Randomized self-checking bench for sequence_player against an
// arithmetic playback model and a reference LFSR.
module tb_sequence_player;

    localparam int IDX_W = 5;
    localparam int ON_T  = 3;
    localparam int OFF_T = 1;
    localparam int PER   = ON_T + OFF_T;
    localparam logic [15:0] SEED = 16'hACE1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tick = 1'b0;
    logic             clear = 1'b0;
    logic             extend = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W-1:0] rd_idx = '0;
    logic [1:0]       rd_num;
    logic [IDX_W:0]   length;
    logic             full;
    logic [1:0]       num;
    logic             pressed;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int phase = 0;
    logic [15:0] lfsr_m;
    logic [1:0]  exp_mem [32];
    int          exp_len = 0;

    sequence_player #(
        .IDX_W(IDX_W), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .clear(clear), .extend(extend),
        .start(start), .rd_idx(rd_idx), .rd_num(rd_num), .length(length),
        .full(full), .num(num), .pressed(pressed), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^14+x^13+x^11, new bit shifted in at the bottom.
    always @(posedge clk or negedge reset) begin
        if (!reset) lfsr_m <= SEED;
        else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    // Advance one cycle; tick fires every fourth cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick  = (phase == 0);
        phase = (phase + 1) % 4;
    endtask

    task automatic do_extend();
        if (exp_len < 32) begin
            exp_mem[exp_len] = lfsr_m[1:0];
            exp_len++;
        end
        extend = 1'b1;
        cyc();
        extend = 1'b0;
        repeat ($urandom_range(0, 3)) cyc();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        exp_len = 0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < exp_len; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            checks++;
            if (rd_num !== exp_mem[i]) begin
                errors++;
                $display("FAIL %s rd_num[%0d] got %0d want %0d", tag, i, rd_num, exp_mem[i]);
            end
        end
        checks++;
        if (length !== (IDX_W+1)'(exp_len) || full !== (exp_len == 32)) begin
            errors++;
            $display("FAIL %s length/full got %0d/%0b want %0d/%0b", tag, length, full, exp_len, exp_len == 32);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) cyc();
        checks++;
        if ({num, pressed, busy, done, full} !== 6'b0 || length !== '0) begin
            errors++;
            $display("FAIL reset_outputs got num=%0d p=%0b b=%0b d=%0b f=%0b len=%0d want all 0",
                     num, pressed, busy, done, full, length);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_extend();
        repeat (3) do_extend();
        check_mem("extend3");
    endtask

    // Playback model: ticks seen after the start cycle fix the position.
    task automatic run_playback(input string tag, input bit inject);
        int  n = 0;
        bit  fin = 0;
        int  idle_after = 0;
        bit  finished = 0;
        bit  e_p, e_b, e_d;
        logic [1:0] e_n;
        int  len_at_start = exp_len;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k < 400; k++) begin
            if (fin) begin
                e_p = 0; e_b = 0; e_d = 0; e_n = 2'd0;
            end else if (n / PER >= len_at_start) begin
                e_p = 0; e_b = 1; e_d = 1; e_n = 2'd0;
            end else begin
                e_p = ((n % PER) < ON_T); e_b = 1; e_d = 0; e_n = exp_mem[n / PER];
            end
            checks++;
            if (pressed !== e_p || busy !== e_b || done !== e_d || num !== e_n) begin
                errors++;
                $display("FAIL %s cycle %0d got p=%0b b=%0b d=%0b n=%0d want p=%0b b=%0b d=%0b n=%0d",
                         tag, k, pressed, busy, done, num, e_p, e_b, e_d, e_n);
            end
            if (e_d) fin = 1;
            if (fin && !e_d) idle_after++;
            if (idle_after == 2) begin
                finished = 1;
                break;
            end
            start  = inject && (k == 2 || k == 9);
            extend = inject && (k == 2 || k == 9);
            if (tick) n++;
            cyc();
        end
        start  = 1'b0;
        extend = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout got no completion want done within 400 cycles", tag);
        end
    endtask

    task automatic test_empty_start();
        do_clear();
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL empty_start got d=%0b b=%0b p=%0b want 1 1 0", done, busy, pressed);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_after got d=%0b b=%0b want 0 0", done, busy);
        end
    endtask

    task automatic test_full();
        logic [1:0] last;
        do_clear();
        repeat (32) do_extend();
        check_mem("fill32");
        last = exp_mem[31];
        do_extend();
        check_mem("extend33");
        rd_idx = 5'd31;
        #1;
        checks++;
        if (rd_num !== last) begin
            errors++;
            $display("FAIL mem31_kept got %0d want %0d", rd_num, last);
        end
    endtask

    task automatic test_clear_abort();
        int rises = 0;
        bit prev = 0;
        do_clear();
        repeat (3) do_extend();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 200 && rises < 2; k++) begin
            if (pressed && !prev) rises++;
            prev = pressed;
            if (rises < 2) cyc();
        end
        checks++;
        if (rises < 2) begin
            errors++;
            $display("FAIL abort_wait got %0d presses want 2", rises);
        end
        do_clear();
        checks++;
        if (pressed !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || length !== '0) begin
            errors++;
            $display("FAIL abort got p=%0b b=%0b d=%0b len=%0d want 0 0 0 0", pressed, busy, done, length);
        end
        for (int k = 0; k < 20; k++) begin
            cyc();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet got d=%0b b=%0b want 0 0", done, busy);
            end
        end
        test_empty_start();
    endtask

    task automatic test_busy_ignore();
        do_clear();
        repeat (3) do_extend();
        run_playback("busy_ignore", 1'b1);
        check_mem("busy_ignore_mem");
    endtask

    task automatic test_reset_mid_on();
        int k = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        while (!pressed && k < 50) begin
            cyc();
            k++;
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({num, pressed, busy, done} !== 5'b0 || length !== '0) begin
            errors++;
            $display("FAIL async_reset got num=%0d p=%0b b=%0b d=%0b len=%0d want 0",
                     num, pressed, busy, done, length);
        end
        exp_len = 0;
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_extend();
        run_playback("play3", 1'b0);
        test_empty_start();
        test_full();
        do_clear();
        repeat (2 + $urandom_range(0, 3)) do_extend();
        run_playback("play_rand", 1'b0);
        test_clear_abort();
        test_busy_ignore();
        test_reset_mid_on();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
